// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing one variable-latency memory/peripheral slave.
// A watchdog aborts accesses the slave never acknowledges and reports them through mX_err.
module mem_bus_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 15,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,
   output logic              m0_err,
   output logic              m0_lock,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              m1_err,
   output logic              m1_lock,
   output logic              s_sel,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Watchdog counts from 0 in the first ACCESS cycle, so the last allowed cycle sees TIMEOUT-1.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   state_t            state_q;
   logic              s_sel_q;
   logic              s_we_q;
   logic [ADDR_W-1:0] s_addr_q;
   logic [DATA_W-1:0] s_wdata_q;
   logic [DATA_W-1:0] rdata_q [2];
   logic [1:0]        done_q;
   logic [1:0]        err_q;
   logic              grant_q;
   logic              grant_d;
   logic              last_grant_q;
   logic [7:0]        wdog_q;
   logic [1:0]        req;
   logic [1:0]        lock;

   assign req = {m1_req, m0_req};

   // On a tie the master that was not served last wins; a lone requester always wins.
   always_comb begin
      grant_d = m1_req;
      if (m0_req && m1_req) begin
         grant_d = ~last_grant_q;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lock
         assign lock[gi] = req[gi] & ~done_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         s_sel_q      <= 1'b0;
         s_we_q       <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         rdata_q[0]   <= '0;
         rdata_q[1]   <= '0;
         done_q       <= '0;
         err_q        <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wdog_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  grant_q   <= grant_d;
                  s_we_q    <= grant_d ? m1_we    : m0_we;
                  s_addr_q  <= grant_d ? m1_addr  : m0_addr;
                  s_wdata_q <= grant_d ? m1_wdata : m0_wdata;
                  s_sel_q   <= 1'b1;
                  wdog_q    <= '0;
                  state_q   <= ACCESS;
               end
            end
            ACCESS: begin
               if (s_ready) begin
                  if (!s_we_q) begin
                     rdata_q[grant_q] <= s_rdata;
                  end
                  done_q[grant_q] <= 1'b1;
                  s_sel_q         <= 1'b0;
                  state_q         <= RESP;
               end else if (wdog_q == WDOG_LAST) begin
                  if (!s_we_q) begin
                     rdata_q[grant_q] <= ERR_DATA;
                  end
                  done_q[grant_q] <= 1'b1;
                  err_q[grant_q]  <= 1'b1;
                  s_sel_q         <= 1'b0;
                  state_q         <= RESP;
               end else begin
                  wdog_q <= wdog_q + 8'd1;
               end
            end
            RESP: begin
               done_q       <= '0;
               err_q        <= '0;
               last_grant_q <= grant_q;
               state_q      <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_sel    = s_sel_q;
   assign s_we     = s_we_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
   assign m0_lock  = lock[0];
   assign m1_lock  = lock[1];

endmodule
